// File: rtl/dcache_store_drain.sv
// dcache_store_drain
//
// Drains the data-cache store buffer into line-wide cache writes. The oldest
// store is popped, its bytes are placed into a line buffer with byte enables,
// and one line write is issued. Draining only happens while the load path is
// idle (cache_busy=0) or while a flush is requested.
//
// Optional feature: define DCACHE_ST_DRAIN_COALESCE_EN to add a COLLECT state
// that merges up to MAX_MERGE same-line stores into one write. When it is
// undefined, every store becomes its own line write.
//
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   sb_empty             store buffer holds no valid entry
//   sb_oldest_addr/data  oldest store (data right-aligned)
//   sb_oldest_size       0=byte 1=half 2=word 3=reserved
//   sb_get_oldest        pop strobe, entry removed at this edge
//   cache_busy           load path owns the cache this cycle
//   flush_req            level; drain regardless of cache_busy
//   flush_done           pulse while flushing with nothing left to drain
//   wr_valid/wr_ready    line write handshake
//   wr_addr              line-aligned write address
//   wr_data/wr_byte_en   byte-lane data and per-byte enables
//   drain_misaligned     pulse when a popped store is dropped as misaligned

module dcache_store_drain #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LINE_W    = 128,
    parameter int unsigned MAX_MERGE = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sb_empty,
    input  logic [ADDR_W-1:0]     sb_oldest_addr,
    input  logic [DATA_W-1:0]     sb_oldest_data,
    input  logic [1:0]            sb_oldest_size,
    output logic                  sb_get_oldest,
    input  logic                  cache_busy,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [LINE_W-1:0]     wr_data,
    output logic [LINE_W/8-1:0]   wr_byte_en,
    output logic                  drain_misaligned
);

    localparam int unsigned LINE_B = LINE_W / 8;
    localparam int unsigned OFF_W  = $clog2(LINE_B);
    localparam int unsigned DATA_B = DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StWrite
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   data_q, data_d;
    logic [LINE_B-1:0]   be_q, be_d;

`ifdef DCACHE_ST_DRAIN_COALESCE_EN
    localparam int unsigned CNT_W = $clog2(MAX_MERGE + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MERGE);
    logic [CNT_W-1:0]    merge_cnt_q, merge_cnt_d;
`endif

    // Decode of the oldest store: line address, byte offset, size, legality.
    logic [OFF_W-1:0]    st_off;
    logic [ADDR_W-1:0]   st_line;
    logic                st_aligned;
    int unsigned         st_bytes;
    logic [LINE_W-1:0]   place_data;
    logic [LINE_B-1:0]   place_be;
    logic                pop_ok;

    assign st_off  = sb_oldest_addr[OFF_W-1:0];
    assign st_line = {sb_oldest_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    // Reset gates the pop so the buffer never loses an entry while we restart.
    assign pop_ok  = !reset && !sb_empty && (!cache_busy || flush_req);

    always_comb begin
        st_aligned = 1'b0;
        st_bytes   = 1;
        case (sb_oldest_size)
            2'd0: begin
                st_aligned = 1'b1;
                st_bytes   = 1;
            end
            2'd1: begin
                st_aligned = !sb_oldest_addr[0];
                st_bytes   = 2;
            end
            2'd2: begin
                st_aligned = (sb_oldest_addr[1:0] == 2'b00);
                st_bytes   = 4;
            end
            default: begin
                st_aligned = 1'b0;
                st_bytes   = 1;
            end
        endcase
    end

    // Store byte i lands on line lane off+i.
    always_comb begin
        place_data = '0;
        place_be   = '0;
        for (int unsigned i = 0; i < DATA_B; i++) begin
            if (i < st_bytes && (32'(st_off) + i) < LINE_B) begin
                place_data[(32'(st_off) + i)*8 +: 8] = sb_oldest_data[i*8 +: 8];
                place_be[32'(st_off) + i]            = 1'b1;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        data_d           = data_q;
        be_d             = be_q;
        sb_get_oldest    = 1'b0;
        drain_misaligned = 1'b0;
`ifdef DCACHE_ST_DRAIN_COALESCE_EN
        merge_cnt_d      = merge_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (pop_ok) begin
                    sb_get_oldest = 1'b1;
                    if (!st_aligned) begin
                        drain_misaligned = 1'b1;
                    end else begin
                        addr_d = st_line;
                        data_d = place_data;
                        be_d   = place_be;
`ifdef DCACHE_ST_DRAIN_COALESCE_EN
                        merge_cnt_d = CNT_W'(1);
                        if (MAX_MERGE > 1) begin
                            state_d = StCollect;
                        end else begin
                            state_d = StWrite;
                        end
`else
                        state_d = StWrite;
`endif
                    end
                end
            end
`ifdef DCACHE_ST_DRAIN_COALESCE_EN
            StCollect: begin
                // Misaligned or other-line stores stay in the buffer for IDLE.
                if (pop_ok && st_aligned && (st_line == addr_q) && (merge_cnt_q < MAX_CNT)) begin
                    sb_get_oldest = 1'b1;
                    for (int unsigned b = 0; b < LINE_B; b++) begin
                        if (place_be[b]) begin
                            data_d[b*8 +: 8] = place_data[b*8 +: 8];
                        end
                    end
                    be_d        = be_q | place_be;
                    merge_cnt_d = merge_cnt_q + CNT_W'(1);
                end else begin
                    state_d = StWrite;
                end
            end
`endif
            StWrite: begin
                if (wr_ready) begin
                    state_d = StIdle;
                    data_d  = '0;
                    be_d    = '0;
`ifdef DCACHE_ST_DRAIN_COALESCE_EN
                    merge_cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
`ifdef DCACHE_ST_DRAIN_COALESCE_EN
            merge_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
`ifdef DCACHE_ST_DRAIN_COALESCE_EN
            merge_cnt_q <= merge_cnt_d;
`endif
        end
    end

    assign wr_valid   = (state_q == StWrite);
    assign wr_addr    = addr_q;
    assign wr_data    = data_q;
    assign wr_byte_en = be_q;
    assign flush_done = !reset && flush_req && (state_q == StIdle) && sb_empty;

endmodule

// File: tb/tb_dcache_store_drain.sv
// Bench for dcache_store_drain: a queue models the store buffer, expected line
// writes are queued as stimulus is issued and compared on each accepted write.

module tb_dcache_store_drain;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sb_empty = 1'b1;
    logic [31:0]   sb_oldest_addr = '0;
    logic [31:0]   sb_oldest_data = '0;
    logic [1:0]    sb_oldest_size = '0;
    logic          sb_get_oldest;
    logic          cache_busy = 1'b0;
    logic          flush_req = 1'b0;
    logic          flush_done;
    logic          wr_valid;
    logic          wr_ready = 1'b1;
    logic [31:0]   wr_addr;
    logic [127:0]  wr_data;
    logic [15:0]   wr_byte_en;
    logic          drain_misaligned;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } st_t;

    typedef struct packed {
        logic [31:0]  addr;
        logic [15:0]  be;
        logic [127:0] data;
    } wr_t;

    st_t sbq[$];
    wr_t expq[$];

    int total = 0;
    int bad = 0;
    int pops = 0;
    int writes = 0;
    int mis_cnt = 0;

    dcache_store_drain #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .LINE_W    (128),
        .MAX_MERGE (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .sb_empty         (sb_empty),
        .sb_oldest_addr   (sb_oldest_addr),
        .sb_oldest_data   (sb_oldest_data),
        .sb_oldest_size   (sb_oldest_size),
        .sb_get_oldest    (sb_get_oldest),
        .cache_busy       (cache_busy),
        .flush_req        (flush_req),
        .flush_done       (flush_done),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_byte_en       (wr_byte_en),
        .drain_misaligned (drain_misaligned)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_st(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        st_t s;
        s.addr = addr;
        s.data = data;
        s.size = size;
        sbq.push_back(s);
    endtask

    task automatic exp_wr(input logic [31:0] addr, input logic [15:0] be, input logic [127:0] data);
        wr_t w;
        w.addr = addr;
        w.be   = be;
        w.data = data;
        expq.push_back(w);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sbq.size() != 0 || expq.size() != 0 || wr_valid) && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(tag, 128'(expq.size()), 128'(0));
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_wr_valid(input string tag);
        int n = 0;
        while (!wr_valid && n < 30) begin
            @(negedge clock);
            n++;
        end
        check(tag, 128'(wr_valid), 128'(1));
    endtask

    // Store buffer model: oldest entry presented just after each edge.
    always @(posedge clock) begin
        #1;
        if (sbq.size() == 0) begin
            sb_empty       = 1'b1;
            sb_oldest_addr = '0;
            sb_oldest_data = '0;
            sb_oldest_size = '0;
        end else begin
            sb_empty       = 1'b0;
            sb_oldest_addr = sbq[0].addr;
            sb_oldest_data = sbq[0].data;
            sb_oldest_size = sbq[0].size;
        end
    end

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clock) begin
        wr_t e;
        if (sb_get_oldest) begin
            pops++;
            if (sbq.size() != 0) void'(sbq.pop_front());
            else check("pop_when_empty", 128'(1), 128'(0));
        end
        if (drain_misaligned) mis_cnt++;
        if (flush_done) check("flush_done_while_writing", 128'(wr_valid), 128'(0));
        if (wr_valid && wr_ready) begin
            writes++;
            if (expq.size() == 0) begin
                check("unexpected_write", 128'(1), 128'(0));
            end else begin
                e = expq.pop_front();
                check("wr_addr", 128'(wr_addr), 128'(e.addr));
                check("wr_byte_en", 128'(wr_byte_en), 128'(e.be));
                check("wr_data", wr_data, e.data);
            end
        end
    end

    initial begin
        int p0;
        int w0;
        int m0;
        int n;

        // Reset values.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_wr_valid", 128'(wr_valid), 128'(0));
        check("rst_wr_addr", 128'(wr_addr), 128'(0));
        check("rst_wr_be", 128'(wr_byte_en), 128'(0));
        check("rst_wr_data", wr_data, 128'(0));
        check("rst_pop", 128'(sb_get_oldest), 128'(0));
        check("rst_flush_done", 128'(flush_done), 128'(0));
        check("rst_misaligned", 128'(drain_misaligned), 128'(0));
        reset = 1'b0;
        @(negedge clock);

        // Single word store.
        p0 = pops;
        push_st(32'h104, 32'hDEADBEEF, 2'd2);
        exp_wr(32'h100, 16'h00F0, 128'h00000000_00000000_DEADBEEF_00000000);
        wait_idle("t1_drain");
        check("t1_pops", 128'(pops - p0), 128'(1));

        // Same-line stores.
        w0 = writes;
        push_st(32'h200, 32'h11111111, 2'd2);
        push_st(32'h201, 32'h000000AA, 2'd0);
        push_st(32'h20C, 32'h22222222, 2'd2);
`ifdef DCACHE_ST_DRAIN_COALESCE_EN
        exp_wr(32'h200, 16'hF00F, 128'h22222222_00000000_00000000_1111AA11);
        wait_idle("t2_drain");
        check("t2_writes", 128'(writes - w0), 128'(1));
`else
        exp_wr(32'h200, 16'h000F, 128'h00000000_00000000_00000000_11111111);
        exp_wr(32'h200, 16'h0002, 128'h00000000_00000000_00000000_0000AA00);
        exp_wr(32'h200, 16'hF000, 128'h22222222_00000000_00000000_00000000);
        wait_idle("t2_drain");
        check("t2_writes", 128'(writes - w0), 128'(3));
`endif

        // Five words to one line, then a different-line pair.
        w0 = writes;
        push_st(32'h300, 32'h1, 2'd2);
        push_st(32'h304, 32'h2, 2'd2);
        push_st(32'h308, 32'h3, 2'd2);
        push_st(32'h30C, 32'h4, 2'd2);
        push_st(32'h300, 32'h5, 2'd2);
`ifdef DCACHE_ST_DRAIN_COALESCE_EN
        exp_wr(32'h300, 16'hFFFF, 128'h00000004_00000003_00000002_00000001);
        exp_wr(32'h300, 16'h000F, 128'h5);
        wait_idle("t3_drain");
        check("t3_writes", 128'(writes - w0), 128'(2));
`else
        exp_wr(32'h300, 16'h000F, 128'h1);
        exp_wr(32'h300, 16'h00F0, 128'h2 << 32);
        exp_wr(32'h300, 16'h0F00, 128'h3 << 64);
        exp_wr(32'h300, 16'hF000, 128'h4 << 96);
        exp_wr(32'h300, 16'h000F, 128'h5);
        wait_idle("t3_drain");
        check("t3_writes", 128'(writes - w0), 128'(5));
`endif
        w0 = writes;
        push_st(32'h300, 32'h6, 2'd2);
        push_st(32'h340, 32'h7, 2'd2);
        exp_wr(32'h300, 16'h000F, 128'h6);
        exp_wr(32'h340, 16'h000F, 128'h7);
        wait_idle("t3b_drain");
        check("t3b_writes", 128'(writes - w0), 128'(2));

        // Backpressure: write held stable, no pops while stalled.
        wr_ready = 1'b0;
        push_st(32'h408, 32'hCAFEF00D, 2'd2);
        exp_wr(32'h400, 16'h0F00, 128'h00000000_CAFEF00D_00000000_00000000);
        wait_wr_valid("t4_wr_valid");
        push_st(32'h50F, 32'h0000005A, 2'd0);
        exp_wr(32'h500, 16'h8000, 128'h5A000000_00000000_00000000_00000000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t4_stall_valid", 128'(wr_valid), 128'(1));
            check("t4_stall_addr", 128'(wr_addr), 128'(32'h400));
            check("t4_stall_be", 128'(wr_byte_en), 128'(16'h0F00));
            check("t4_stall_data", wr_data, 128'h00000000_CAFEF00D_00000000_00000000);
            check("t4_stall_pop", 128'(sb_get_oldest), 128'(0));
        end
        wr_ready = 1'b1;
        wait_idle("t4_drain");

        // Cache busy blocks draining; flush overrides it.
        cache_busy = 1'b1;
        p0 = pops;
        push_st(32'h600, 32'hA5A5A5A5, 2'd2);
        push_st(32'h642, 32'h0000BEEF, 2'd1);
        exp_wr(32'h600, 16'h000F, 128'hA5A5A5A5);
        exp_wr(32'h640, 16'h000C, 128'hBEEF0000);
        repeat (6) @(negedge clock);
        check("t5_busy_no_pop", 128'(pops - p0), 128'(0));
        flush_req = 1'b1;
        n = 0;
        while (!flush_done && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("t5_flush_done", 128'(flush_done), 128'(1));
        check("t5_flush_pops", 128'(pops - p0), 128'(2));
        check("t5_flush_exp_left", 128'(expq.size()), 128'(0));
        flush_req = 1'b0;
        cache_busy = 1'b0;
        @(negedge clock);
        check("t5_flush_done_drop", 128'(flush_done), 128'(0));

        // Misaligned half is popped and dropped.
        p0 = pops;
        w0 = writes;
        m0 = mis_cnt;
        push_st(32'h103, 32'h0000BEEF, 2'd1);
        repeat (6) @(negedge clock);
        check("t6_pops", 128'(pops - p0), 128'(1));
        check("t6_misaligned", 128'(mis_cnt - m0), 128'(1));
        check("t6_no_write", 128'(writes - w0), 128'(0));
        check("t6_wr_valid", 128'(wr_valid), 128'(0));

        // Reset while a write is pending.
        w0 = writes;
        wr_ready = 1'b0;
        push_st(32'h700, 32'h12345678, 2'd2);
        exp_wr(32'h700, 16'h000F, 128'h12345678);
        wait_wr_valid("t7_wr_valid");
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("t7_rst_valid", 128'(wr_valid), 128'(0));
        check("t7_rst_addr", 128'(wr_addr), 128'(0));
        check("t7_rst_be", 128'(wr_byte_en), 128'(0));
        check("t7_rst_data", wr_data, 128'(0));
        check("t7_rst_pop", 128'(sb_get_oldest), 128'(0));
        expq.delete();
        @(negedge clock);
        reset = 1'b0;
        wr_ready = 1'b1;
        repeat (4) @(negedge clock);
        check("t7_after_valid", 128'(wr_valid), 128'(0));
        check("t7_no_write", 128'(writes - w0), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
